// File: rtl/aesl_deadlock_pkg.sv
// Shared constants for the userdma dataflow deadlock monitor.
// Defines process/stream counts and the bit positions inside the idle-flag vector.
package aesl_deadlock_pkg;

    localparam int unsigned NUM_PROC = 5;
    localparam int unsigned NUM_AXIS = 2;
    localparam int unsigned NUM_IDLE = 9;

    localparam int unsigned IDX_TOP_IDLE     = 5;
    localparam int unsigned IDX_AXIS0_OWN_LO = 6;
    localparam int unsigned IDX_AXIS0_OWN_HI = 7;
    localparam int unsigned IDX_AXIS1_OWN    = 8;

endpackage

// File: rtl/aesl_deadlock_persist.sv
// Persistence filter: a saturating count of consecutive qualifying cycles and
// a registered flag that fires once the count reaches STALL_CYCLES.
module aesl_deadlock_persist #(
    parameter int unsigned STALL_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cond,
    output logic o_block
);

    localparam int unsigned CNT_W = $clog2(STALL_CYCLES + 1);
    localparam int unsigned CMP_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_block;
    logic             w_fire;

    // Compare cnt+1 in a widened domain so STALL_CYCLES=1 needs no special case.
    assign w_fire = (CMP_W'(r_cnt) + CMP_W'(1)) >= CMP_W'(STALL_CYCLES);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_block <= 1'b0;
        end else begin
            if (i_cond) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_block <= i_cond & w_fire;
        end
    end

    assign o_block = r_block;

endmodule

// File: rtl/aesl_deadlock_idx0_monitor.sv
// Deadlock detector for the five-process userdma dataflow region: flags when every
// active process is stalled on an internal channel with no stream wait pending.
module aesl_deadlock_idx0_monitor
    import aesl_deadlock_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_IDLE-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    output logic                block
);

    logic [NUM_PROC-1:0] w_active;
    logic [NUM_PROC-1:0] w_stalled;
    logic                w_axis_wait0;
    logic                w_axis_wait1;
    logic                w_ext_wait;
    logic                w_cond;

    assign w_active  = ~inst_idle_sigs[NUM_PROC-1:0];
    assign w_stalled = w_active & inst_block_sigs;

    // A stream wait only counts while its owning process is still running.
    assign w_axis_wait0 = axis_block_sigs[0]
                        & ~(inst_idle_sigs[IDX_AXIS0_OWN_LO] & inst_idle_sigs[IDX_AXIS0_OWN_HI]);
    assign w_axis_wait1 = axis_block_sigs[1] & ~inst_idle_sigs[IDX_AXIS1_OWN];
    assign w_ext_wait   = w_axis_wait0 | w_axis_wait1;

    assign w_cond = ~inst_idle_sigs[IDX_TOP_IDLE]
                  & (|w_active)
                  & (&(w_stalled | ~w_active))
                  & ~w_ext_wait;

    aesl_deadlock_persist #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_persist (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_cond (w_cond),
        .o_block(block)
    );

endmodule

// File: tb/tb_aesl_deadlock_idx0_monitor.sv
// Bench for the deadlock monitor: table of input phases with end-of-phase checks,
// plus a cycle-by-cycle reference model whose predictions flow through a queue.
module tb_aesl_deadlock_idx0_monitor;

    localparam int S4 = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] axis_block_sigs;
    logic [8:0] inst_idle_sigs;
    logic [4:0] inst_block_sigs;
    logic       block4;
    logic       block1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] axis;
        logic [8:0] idle;
        logic [4:0] blk;
        int         cycles;
        logic       exp_final;
    } vec_t;

    typedef struct {
        logic b4;
        logic b1;
    } exp_t;

    vec_t tbl[22];
    exp_t sb_q[$];
    int   m_cnt4;

    always #5 clock = ~clock;

    aesl_deadlock_idx0_monitor #(.STALL_CYCLES(4)) dut4 (
        .clock          (clock),
        .reset          (reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .block          (block4)
    );

    aesl_deadlock_idx0_monitor #(.STALL_CYCLES(1)) dut1 (
        .clock          (clock),
        .reset          (reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .block          (block1)
    );

    function automatic logic model_cond(logic [1:0] ax, logic [8:0] id, logic [4:0] bk);
        logic any_active = 1'b0;
        logic all_stalled = 1'b1;
        logic ext;
        for (int i = 0; i < 5; i++) begin
            if (!id[i]) begin
                any_active = 1'b1;
                if (!bk[i]) all_stalled = 1'b0;
            end
        end
        ext = (ax[0] && !(id[6] && id[7])) || (ax[1] && !id[8]);
        return !id[5] && any_active && all_stalled && !ext;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model predicts at the edge, DUT is compared at the following negedge.
    task automatic step(input string name);
        exp_t e;
        logic c;
        @(posedge clock);
        c = model_cond(axis_block_sigs, inst_idle_sigs, inst_block_sigs);
        e.b4 = c && (m_cnt4 >= S4 - 1);
        e.b1 = c;
        m_cnt4 = c ? ((m_cnt4 + 1 > S4) ? S4 : m_cnt4 + 1) : 0;
        sb_q.push_back(e);
        @(negedge clock);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_s4"}, block4, e.b4);
            check({name, "_s1"}, block1, e.b1);
        end
    endtask

    task automatic add(input int i, input string n, input logic [1:0] ax, input logic [8:0] id,
                       input logic [4:0] bk, input int cyc, input logic ef);
        tbl[i] = '{n, ax, id, bk, cyc, ef};
    endtask

    initial begin
        add( 0, "all_idle",      2'b00, 9'h01F, 5'h00, 20, 1'b0);
        add( 1, "stall_pre",     2'b00, 9'h000, 5'h1F,  3, 1'b0);
        add( 2, "stall_fire",    2'b00, 9'h000, 5'h1F,  1, 1'b1);
        add( 3, "stall_hold",    2'b00, 9'h000, 5'h1F,  6, 1'b1);
        add( 4, "axis0_wait",    2'b01, 9'h000, 5'h1F,  5, 1'b0);
        add( 5, "axis0_clr_pre", 2'b00, 9'h000, 5'h1F,  3, 1'b0);
        add( 6, "axis0_clr",     2'b00, 9'h000, 5'h1F,  1, 1'b1);
        add( 7, "axis0_own_idl", 2'b01, 9'h0C0, 5'h1F,  4, 1'b1);
        add( 8, "axis1_wait",    2'b10, 9'h000, 5'h1F,  1, 1'b0);
        add( 9, "axis1_own_pre", 2'b10, 9'h100, 5'h1F,  3, 1'b0);
        add(10, "axis1_own",     2'b10, 9'h100, 5'h1F,  1, 1'b1);
        add(11, "idle_gap",      2'b00, 9'h01F, 5'h00,  1, 1'b0);
        add(12, "p12_a",         2'b00, 9'h019, 5'h06,  2, 1'b0);
        add(13, "p12_drop",      2'b00, 9'h019, 5'h02,  1, 1'b0);
        add(14, "p12_pre",       2'b00, 9'h019, 5'h06,  3, 1'b0);
        add(15, "p12_fire",      2'b00, 9'h019, 5'h06,  1, 1'b1);
        add(16, "one_unblocked", 2'b00, 9'h000, 5'h1E, 10, 1'b0);
        add(17, "top_idle",      2'b00, 9'h020, 5'h1F, 10, 1'b0);
        add(18, "idle_blk_pre",  2'b00, 9'h001, 5'h1E,  3, 1'b0);
        add(19, "idle_blk",      2'b00, 9'h001, 5'h1E,  1, 1'b1);
        add(20, "ext_pulse",     2'b01, 9'h000, 5'h1F,  1, 1'b0);
        add(21, "restall",       2'b00, 9'h000, 5'h1F,  4, 1'b1);

        reset           = 1'b1;
        axis_block_sigs = 2'b00;
        inst_idle_sigs  = 9'h01F;
        inst_block_sigs = 5'h00;
        m_cnt4          = 0;
        #2;
        check("reset_s4", block4, 1'b0);
        check("reset_s1", block1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            axis_block_sigs = tbl[i].axis;
            inst_idle_sigs  = tbl[i].idle;
            inst_block_sigs = tbl[i].blk;
            for (int k = 0; k < tbl[i].cycles; k++) step(tbl[i].name);
            check({tbl[i].name, "_final"}, block4, tbl[i].exp_final);
        end

        // Reset pulse in the middle of an established stall.
        check("pre_rst_block", block4, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_async_s4", block4, 1'b0);
        check("rst_async_s1", block1, 1'b0);
        m_cnt4 = 0;
        @(posedge clock);
        #1;
        check("rst_held_s4", block4, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step("rst_rearm");
        check("rst_rearm_pre", block4, 1'b0);
        step("rst_rearm_fire");
        check("rst_rearm_final", block4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
